cpu_module_ex_muldiv: RTL and testbench

CPU_MODULE_EX_MULDIV -- requirements
Module: cpu_module_ex_muldiv

---
 rtl/cpu_module_ex_muldiv_pkg.sv | 27 ++
 rtl/cpu_module_ex_muldiv_md.sv | 87 ++++++++
 rtl/cpu_module_ex_muldiv.sv | 122 ++++++++++++
 tb/tb_cpu_module_ex_muldiv.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_module_ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Holds the MdOp encodings, the FSM state encoding and the iteration count
// of the radix-2 datapath.
package cpu_module_ex_muldiv_pkg;

  localparam int DATA_W  = 32;
  localparam int MD_ITER = 32;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/cpu_module_ex_muldiv_md.sv
// cpu_module_md_core: iterative unsigned-magnitude multiply/divide datapath.
// One radix-2 shift-add (mult) or restoring shift-subtract (div) step per
// cycle while run is high; the sign-corrected result is valid once the last
// step has been taken.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           latch operands/flags and clear the step counter
//   run             take one step this cycle
//   is_div          1: divide (a = dividend, b = divisor), 0: multiply
//   neg_res         negate product / quotient
//   neg_rem         negate remainder
//   a_mag, b_mag    operand magnitudes
//   result          {HI, LO}: product, or {remainder, quotient}
//   done            high during the cycle that takes the final step
module cpu_module_md_core
  import cpu_module_ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        run,
  input  logic        is_div,
  input  logic        neg_res,
  input  logic        neg_rem,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [63:0] result,
  output logic        done
);

  // work holds {acc, multiplier} for mult and {remainder, quotient} for div
  logic [63:0] work;
  logic [63:0] work_next;
  logic [31:0] opnd;
  logic [5:0]  count;
  logic        div_mode;
  logic        neg_res_q;
  logic        neg_rem_q;
  logic [32:0] add_sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  always_comb begin
    add_sum = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
    rem_sh  = {work[63:32], work[31]};
    // diff[32] set means the trial subtraction went negative: restore
    diff    = rem_sh - {1'b0, opnd};
    if (div_mode) begin
      if (diff[32]) work_next = {rem_sh[31:0], work[30:0], 1'b0};
      else          work_next = {diff[31:0], work[30:0], 1'b1};
    end else begin
      work_next = {add_sum, work[31:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work      <= '0;
      opnd      <= '0;
      count     <= '0;
      div_mode  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (start) begin
      work      <= {32'd0, (is_div ? a_mag : b_mag)};
      opnd      <= is_div ? b_mag : a_mag;
      count     <= '0;
      div_mode  <= is_div;
      neg_res_q <= neg_res;
      neg_rem_q <= neg_rem;
    end else if (run) begin
      work  <= work_next;
      count <= count + 6'd1;
    end
  end

  always_comb begin
    done = run && (count == 6'(MD_ITER - 1));
    if (div_mode) begin
      result = {(neg_rem_q ? -work[63:32] : work[63:32]),
                (neg_res_q ? -work[31:0]  : work[31:0])};
    end else begin
      result = neg_res_q ? -work : work;
    end
  end

endmodule

// File: rtl/cpu_module_ex_muldiv.sv
// cpu_module_ex_muldiv: EX-stage MIPS-style HI/LO multiply/divide unit.
// IDLE -> RUN (32 steps) -> FIX (sign fix, HI/LO write) -> IDLE.
// Optional feature macro MDU_FAST_MULT_EN: MULT/MULTU complete in one cycle
// from IDLE; DIV/DIVU remain iterative.
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   MdOp_ex                 op code (see md_op_e; 9..15 act as NONE)
//   RsData_ex, RtData_ex    forwarded operands
//   MdStall                 freeze request to the hazard unit
//   MdResult_ex             HI for MFHI, LO for MFLO, else 0
//   Hi, Lo                  architectural HI/LO registers
module cpu_module_ex_muldiv
  import cpu_module_ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  MdOp_ex,
  input  logic [31:0] RsData_ex,
  input  logic [31:0] RtData_ex,
  output logic        MdStall,
  output logic [31:0] MdResult_ex,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  md_state_e   state;
  md_state_e   state_next;
  logic        op_valid;
  logic        op_signed;
  logic        op_div;
  logic        op_iter;
  logic        start;
  logic        rs_neg;
  logic        rt_neg;
  logic        neg_res;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [63:0] core_result;
  logic        core_done;

  always_comb begin
    op_valid  = (MdOp_ex != MD_NONE) && (MdOp_ex <= MD_MFLO);
    op_signed = (MdOp_ex == MD_MULT) || (MdOp_ex == MD_DIV);
    op_div    = (MdOp_ex == MD_DIV)  || (MdOp_ex == MD_DIVU);
`ifdef MDU_FAST_MULT_EN
    op_iter   = op_div;
`else
    op_iter   = op_div || (MdOp_ex == MD_MULT) || (MdOp_ex == MD_MULTU);
`endif
    start     = (state == ST_IDLE) && op_iter;
    rs_neg    = op_signed && RsData_ex[31];
    rt_neg    = op_signed && RtData_ex[31];
    rs_mag    = rs_neg ? -RsData_ex : RsData_ex;
    rt_mag    = rt_neg ? -RtData_ex : RtData_ex;
    // a zero divisor must leave the all-ones quotient unnegated
    neg_res   = (rs_neg ^ rt_neg) && !(op_div && (RtData_ex == 32'd0));
  end

  cpu_module_md_core u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .run    (state == ST_RUN),
    .is_div (op_div),
    .neg_res(neg_res),
    .neg_rem(rs_neg),
    .a_mag  (rs_mag),
    .b_mag  (rt_mag),
    .result (core_result),
    .done   (core_done)
  );

`ifdef MDU_FAST_MULT_EN
  logic [63:0] fast_prod;
  always_comb begin
    fast_prod = {{32{rs_neg}}, RsData_ex} * {{32{rt_neg}}, RtData_ex};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start)     state_next = ST_RUN;
      ST_RUN:  if (core_done) state_next = ST_FIX;
      ST_FIX:                 state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Hi <= '0;
      Lo <= '0;
    end else if (state == ST_FIX) begin
      {Hi, Lo} <= core_result;
    end else if (state == ST_IDLE) begin
      case (MdOp_ex)
        MD_MTHI: Hi <= RsData_ex;
        MD_MTLO: Lo <= RsData_ex;
`ifdef MDU_FAST_MULT_EN
        MD_MULT, MD_MULTU: {Hi, Lo} <= fast_prod;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    MdStall     = (state != ST_IDLE) && op_valid;
    MdResult_ex = '0;
    if (state == ST_IDLE) begin
      if (MdOp_ex == MD_MFHI) MdResult_ex = Hi;
      if (MdOp_ex == MD_MFLO) MdResult_ex = Lo;
    end
  end

endmodule

// File: tb/tb_cpu_module_ex_muldiv.sv
module tb_cpu_module_ex_muldiv;
  import cpu_module_ex_muldiv_pkg::*;

`ifdef MDU_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam logic [3:0] LONG_OP = FAST ? 4'(MD_DIV) : 4'(MD_MULT);

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  MdOp_ex;
  logic [31:0] RsData_ex;
  logic [31:0] RtData_ex;
  logic        MdStall;
  logic [31:0] MdResult_ex;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi = 32'd0;
  logic [31:0] mlo = 32'd0;

  always #5 clk = ~clk;

  cpu_module_ex_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .MdOp_ex    (MdOp_ex),
    .RsData_ex  (RsData_ex),
    .RtData_ex  (RtData_ex),
    .MdStall    (MdStall),
    .MdResult_ex(MdResult_ex),
    .Hi         (Hi),
    .Lo         (Lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural result {HI, LO} of an op, from plain arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op,
                                        input logic [31:0] rs,
                                        input logic [31:0] rt);
    longint      sa, sb, q, m;
    logic [63:0] ua, ub, r;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    r  = {mhi, mlo};
    case (op)
      4'd1: r = 64'(sa * sb);
      4'd2: r = ua * ub;
      4'd3: begin
        if (rt == 32'd0) r = {rs, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      4'd4: begin
        if (rt == 32'd0) r = {rs, 32'hFFFF_FFFF};
        else r = {32'(ua % ub), 32'(ua / ub)};
      end
      default: r = {mhi, mlo};
    endcase
    return r;
  endfunction

  // Issue one mult/div op, then hold MFHI/MFLO and count stall cycles.
  task automatic do_md(input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input bit read_hi,
                       input string name);
    logic [63:0] exp;
    int stalls;
    int want;
    exp  = model(op, rs, rt);
    want = (FAST && (op == 4'd1 || op == 4'd2)) ? 0 : MD_ITER + 1;
    MdOp_ex = op; RsData_ex = rs; RtData_ex = rt;
    #1;
    checks++;
    if (MdStall !== 1'b0) begin
      errors++;
      $display("FAIL %s start_stall got %b want 0", name, MdStall);
    end
    tick();
    MdOp_ex = read_hi ? 4'(MD_MFHI) : 4'(MD_MFLO);
    RsData_ex = $urandom; RtData_ex = $urandom;
    #1;
    stalls = 0;
    while (MdStall === 1'b1 && stalls < 40) begin
      tick();
      stalls++;
    end
    checks++;
    if (stalls != want) begin
      errors++;
      $display("FAIL %s stall_cycles got %0d want %0d", name, stalls, want);
    end
    checks++;
    if (MdResult_ex !== (read_hi ? exp[63:32] : exp[31:0])) begin
      errors++;
      $display("FAIL %s mf_result got %h want %h", name, MdResult_ex,
               read_hi ? exp[63:32] : exp[31:0]);
    end
    checks++;
    if ({Hi, Lo} !== exp) begin
      errors++;
      $display("FAIL %s hilo got %h_%h want %h", name, Hi, Lo, exp);
    end
    mhi = exp[63:32];
    mlo = exp[31:0];
    MdOp_ex = MD_NONE;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    MdOp_ex = MD_MTHI; RsData_ex = 32'hDEAD_BEEF; RtData_ex = 32'h1;
    tick();
    tick();
    MdOp_ex = MD_NONE;
    #1;
    checks++;
    if ({Hi, Lo} !== 64'd0) begin
      errors++;
      $display("FAIL reset_hilo got %h_%h want 0", Hi, Lo);
    end
    checks++;
    if (MdStall !== 1'b0 || MdResult_ex !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b res=%h want 0/0", MdStall, MdResult_ex);
    end
    rst = 1'b0;
    mhi = 32'd0; mlo = 32'd0;
  endtask

  task automatic test_vectors();
    do_md(MD_MULT, 32'hFFFF_FFFF, 32'h2, 1'b0, "mult_neg1x2");
    checks++;
    if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL mult_vec got %h_%h want ffffffff_fffffffe", Hi, Lo);
    end
    do_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu_max");
    checks++;
    if ({Hi, Lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL multu_vec got %h_%h want fffffffe_00000001", Hi, Lo);
    end
    do_md(MD_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, "div_m7_2");
    checks++;
    if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      errors++;
      $display("FAIL div_vec got %h_%h want ffffffff_fffffffd", Hi, Lo);
    end
    do_md(MD_DIVU, 32'h1234, 32'h0, 1'b1, "divu_by0");
    checks++;
    if ({Hi, Lo} !== 64'h0000_1234_FFFF_FFFF) begin
      errors++;
      $display("FAIL divu0_vec got %h_%h want 00001234_ffffffff", Hi, Lo);
    end
    do_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    checks++;
    if ({Hi, Lo} !== 64'h0000_0000_8000_0000) begin
      errors++;
      $display("FAIL div_ovf_vec got %h_%h want 00000000_80000000", Hi, Lo);
    end
    do_md(MD_DIV, 32'hFFFF_FFF0, 32'h0, 1'b0, "div_neg_by0");
    checks++;
    if ({Hi, Lo} !== 64'hFFFF_FFF0_FFFF_FFFF) begin
      errors++;
      $display("FAIL div_neg0_vec got %h_%h want fffffff0_ffffffff", Hi, Lo);
    end
  endtask

  task automatic test_divu_mfhi();
    do_md(MD_DIVU, 32'd100, 32'd7, 1'b1, "divu_100_7");
    checks++;
    if (MdResult_ex !== 32'h2) begin
      errors++;
      $display("FAIL divu_mfhi got %h want 00000002", MdResult_ex);
    end
    MdOp_ex = MD_MFLO;
    #1;
    checks++;
    if (MdResult_ex !== 32'hE) begin
      errors++;
      $display("FAIL divu_mflo got %h want 0000000e", MdResult_ex);
    end
    MdOp_ex = MD_NONE;
  endtask

  task automatic test_mt_mf();
    logic [31:0] v;
    int stall_seen;
    stall_seen = 0;
    MdOp_ex = MD_MTLO; RsData_ex = 32'h55; RtData_ex = $urandom;
    #1;
    if (MdStall) stall_seen++;
    tick();
    MdOp_ex = MD_MFLO; RsData_ex = $urandom;
    #1;
    if (MdStall) stall_seen++;
    checks++;
    if (MdResult_ex !== 32'h55) begin
      errors++;
      $display("FAIL mtlo_mflo got %h want 00000055", MdResult_ex);
    end
    mlo = 32'h55;
    v = $urandom;
    MdOp_ex = MD_MTHI; RsData_ex = v;
    #1;
    if (MdStall) stall_seen++;
    tick();
    MdOp_ex = MD_MFHI; RsData_ex = $urandom;
    #1;
    if (MdStall) stall_seen++;
    checks++;
    if (MdResult_ex !== v || Lo !== 32'h55) begin
      errors++;
      $display("FAIL mthi_mfhi got %h lo=%h want %h lo=00000055", MdResult_ex, Lo, v);
    end
    mhi = v;
    checks++;
    if (stall_seen != 0) begin
      errors++;
      $display("FAIL mt_mf_stall got %0d stalled cycles want 0", stall_seen);
    end
    MdOp_ex = MD_NONE;
  endtask

  task automatic test_reset_mid();
    MdOp_ex = LONG_OP; RsData_ex = $urandom; RtData_ex = $urandom | 32'h1;
    tick();
    MdOp_ex = MD_NONE;
    repeat (10) tick();
    rst = 1'b1;
    MdOp_ex = MD_MTHI; RsData_ex = 32'hCAFE_F00D;
    tick();
    rst = 1'b0;
    MdOp_ex = MD_MFHI;
    #1;
    mhi = 32'd0; mlo = 32'd0;
    checks++;
    if (MdStall !== 1'b0 || MdResult_ex !== 32'd0) begin
      errors++;
      $display("FAIL midrst_idle got stall=%b res=%h want 0/0", MdStall, MdResult_ex);
    end
    checks++;
    if ({Hi, Lo} !== 64'd0) begin
      errors++;
      $display("FAIL midrst_hilo got %h_%h want 0", Hi, Lo);
    end
    MdOp_ex = MD_NONE;
    repeat (30) tick();
    checks++;
    if ({Hi, Lo} !== 64'd0) begin
      errors++;
      $display("FAIL midrst_no_partial got %h_%h want 0", Hi, Lo);
    end
    do_md(MD_MULT, 32'hFFFF_FFF9, 32'h0000_0003, 1'b0, "after_rst_mult");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, x, y;
    logic [63:0] exp_div;
    int stalls;
    a = $urandom; b = ($urandom & 32'hFFFF) | 32'h1;
    x = $urandom; y = $urandom;
    exp_div = model(MD_DIV, a, b);
    MdOp_ex = MD_DIV; RsData_ex = a; RtData_ex = b;
    tick();
    MdOp_ex = 4'hC; RsData_ex = x; RtData_ex = y;
    #1;
    checks++;
    if (MdStall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_invalid_op got stall=%b want 0", MdStall);
    end
    MdOp_ex = MD_MULT;
    #1;
    stalls = 0;
    while (MdStall === 1'b1 && stalls < 40) begin
      tick();
      stalls++;
    end
    checks++;
    if (stalls != MD_ITER + 1 || {Hi, Lo} !== exp_div) begin
      errors++;
      $display("FAIL b2b_div got stalls=%0d hilo=%h_%h want %0d %h",
               stalls, Hi, Lo, MD_ITER + 1, exp_div);
    end
    mhi = exp_div[63:32]; mlo = exp_div[31:0];
    do_md(MD_MULT, x, y, 1'b1, "b2b_mult");
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] rs, rt;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(1, 6));
      rs = $urandom;
      rt = $urandom;
      case ($urandom_range(0, 7))
        0: rt = 32'd0;
        1: begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
        2: rt = rt & 32'hFF;
        default: ;
      endcase
      if (op == 4'd5 || op == 4'd6) begin
        MdOp_ex = op; RsData_ex = rs; RtData_ex = rt;
        tick();
        if (op == 4'd5) mhi = rs; else mlo = rs;
        MdOp_ex = (op == 4'd5) ? 4'(MD_MFHI) : 4'(MD_MFLO);
        #1;
        checks++;
        if (MdResult_ex !== rs || Hi !== mhi || Lo !== mlo) begin
          errors++;
          $display("FAIL rand_mt[%0d] got res=%h hi=%h lo=%h want %h %h %h",
                   i, MdResult_ex, Hi, Lo, rs, mhi, mlo);
        end
        MdOp_ex = MD_NONE;
      end else begin
        do_md(op, rs, rt, i[0], $sformatf("rand_op%0d[%0d]", op, i));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    MdOp_ex = MD_NONE;
    RsData_ex = 32'd0;
    RtData_ex = 32'd0;
    test_reset();
    test_vectors();
    test_divu_mfhi();
    test_mt_mf();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
